// File: rtl/imem_arb_pkg.sv
// Shared definitions for the instruction-memory arbiter.
// Holds the response-select encoding, the streak counter width and the
// default memory geometry used by the arbiter, the memory and the fetch stage.
package imem_arb_pkg;

  localparam int IMEM_ADDR_W = 5;
  localparam int IMEM_DATA_W = 32;
  localparam int IMEM_DEPTH  = 16;

  // Width of the fetch-starvation streak counter (STARVE_MAX <= 15).
  localparam int STREAK_W = 4;

  // Which requester owns the read response in the cycle after a grant.
  typedef enum logic [1:0] {
    RESP_NONE  = 2'd0,
    RESP_FETCH = 2'd1,
    RESP_LOAD  = 2'd2
  } resp_sel_e;

endpackage

// File: rtl/imem_arb_starve_ctr.sv
// Fetch-starvation streak counter.
// Counts consecutive loader grants taken while fetch was also requesting and
// raises force_f_o once the count reaches STARVE_MAX, so the next contested
// cycle goes to fetch.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   f_req_i    fetch is requesting this cycle
//   f_gnt_i    fetch granted this cycle
//   l_gnt_i    loader granted this cycle
//   lock_i     loader exclusive mode; holds the streak at zero
//   force_f_o  streak has reached STARVE_MAX
module imem_arb_starve_ctr
  import imem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic f_req_i,
  input  logic f_gnt_i,
  input  logic l_gnt_i,
  input  logic lock_i,
  output logic force_f_o
);

  localparam logic [STREAK_W-1:0] MAX_L = STREAK_W'(STARVE_MAX);

  logic [STREAK_W-1:0] streak_q;
  logic [STREAK_W-1:0] streak_d;

  // A loader grant only counts against fetch when fetch was actually waiting.
  always_comb begin
    streak_d = streak_q;
    if (lock_i || !f_req_i || f_gnt_i) begin
      streak_d = '0;
    end else if (l_gnt_i && (streak_q != MAX_L)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

  assign force_f_o = (streak_q == MAX_L);

endmodule

// File: rtl/imem_arbiter.sv
// Two-port arbiter in front of the single-port instruction memory.
// Shares the memory between the core fetch port (read-only) and the
// loader/debug port (read/write), one access per cycle, read data returned
// exactly one cycle after the grant.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   f_req/f_addr                  fetch request; f_ready = grant
//   f_rvalid/f_rdata              fetch read response
//   l_req/l_we/l_lock/l_addr/l_wdata  loader request; l_ready = grant
//   l_rvalid/l_rdata              loader read response
//   l_err                         out-of-range loader access accepted
//   mem_addr/mem_wdata/mem_rw     memory drive (mem_rw low = write)
//   mem_rdata                     registered memory read data
//   dbg_resp_sel                  response-tracking state
//
// Handshake: a requester raises req with stable addr/we/wdata and keeps them
// until it sees its ready high; the access is accepted on the rising edge
// where ready = 1. Ready is a combinational grant, never registered, and
// rvalid carries no back-pressure.
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W     = IMEM_ADDR_W,
  parameter int DATA_W     = IMEM_DATA_W,
  parameter int DEPTH      = IMEM_DEPTH,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ready,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic              l_lock,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_ready,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              l_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rw,
  input  logic [DATA_W-1:0] mem_rdata,
  output resp_sel_e         dbg_resp_sel
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic      f_oor;
  logic      l_oor;
  logic      f_gnt;
  logic      l_gnt;
  logic      force_f;
  resp_sel_e resp_sel_q;
  logic      oor_q;

  assign f_oor = ({1'b0, f_addr} >= DEPTH_L);
  assign l_oor = ({1'b0, l_addr} >= DEPTH_L);

  // Loader wins contested cycles until the streak saturates. Grants are
  // masked during reset so nothing reaches the memory while rst is high.
  assign f_gnt = !rst && f_req && !l_lock && (!l_req || force_f);
  assign l_gnt = !rst && l_req && !f_gnt;

  assign f_ready = f_gnt;
  assign l_ready = l_gnt;
  assign l_err   = l_gnt && l_oor;

  imem_arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve_ctr (
    .clk      (clk),
    .rst      (rst),
    .f_req_i  (f_req),
    .f_gnt_i  (f_gnt),
    .l_gnt_i  (l_gnt),
    .lock_i   (l_lock),
    .force_f_o(force_f)
  );

  // Memory drive. The write strobe only drops for an in-range loader write.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_rw    = 1'b1;
    if (l_gnt) begin
      mem_addr  = l_addr;
      mem_wdata = l_wdata;
      mem_rw    = !(l_we && !l_oor);
    end else if (f_gnt) begin
      mem_addr = f_addr;
    end
  end

  // Response tracking: remembers who owns the read data arriving next cycle
  // and whether it must be forced to zero for an out-of-range address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_sel_q <= RESP_NONE;
      oor_q      <= 1'b0;
    end else if (f_gnt) begin
      resp_sel_q <= RESP_FETCH;
      oor_q      <= f_oor;
    end else if (l_gnt && !l_we) begin
      resp_sel_q <= RESP_LOAD;
      oor_q      <= l_oor;
    end else begin
      resp_sel_q <= RESP_NONE;
      oor_q      <= 1'b0;
    end
  end

  assign f_rvalid     = (resp_sel_q == RESP_FETCH);
  assign l_rvalid     = (resp_sel_q == RESP_LOAD);
  assign f_rdata      = (f_rvalid && !oor_q) ? mem_rdata : '0;
  assign l_rdata      = (l_rvalid && !oor_q) ? mem_rdata : '0;
  assign dbg_resp_sel = resp_sel_q;

endmodule

// File: tb/tb_imem_arbiter.sv
module tb_imem_arbiter;
  import imem_arb_pkg::*;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_ready;
  logic          f_rvalid;
  logic [DW-1:0] f_rdata;
  logic          l_req;
  logic          l_we;
  logic          l_lock;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic          l_ready;
  logic          l_rvalid;
  logic [DW-1:0] l_rdata;
  logic          l_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rw;
  logic [DW-1:0] mem_rdata;
  resp_sel_e     dbg_resp_sel;

  imem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .STARVE_MAX(4)
  ) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_ready(f_ready),
    .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr),
    .l_wdata(l_wdata), .l_ready(l_ready), .l_rvalid(l_rvalid),
    .l_rdata(l_rdata), .l_err(l_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw),
    .mem_rdata(mem_rdata), .dbg_resp_sel(dbg_resp_sel)
  );

  // ---------------- memory model (registered output) ----------------
  function automatic logic [DW-1:0] boot_word(input int i);
    case (i)
      0:       return 32'h0000_0713;
      1:       return 32'h00A0_0613;
      2:       return 32'h00E6_8733;
      3:       return 32'h0016_8693;
      default: return 32'h0000_1000 + DW'(i);
    endcase
  endfunction

  // Upper address bits are ignored, so an out-of-range write that leaked
  // through would alias onto a real word.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= boot_word(i);
    end else if (mem_rw === 1'b0) begin
      mem[mem_addr[3:0]] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr[3:0]];
  end

  // ---------------- scoreboard ----------------
  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] exp_f_q [$];
  logic [DW-1:0] exp_l_q [$];
  logic [DW-1:0] model_mem [DEPTH];

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic fr, input logic [AW-1:0] fa, input logic lr,
                       input logic lw, input logic lk, input logic [AW-1:0] la,
                       input logic [DW-1:0] ld);
    f_req   = fr;
    f_addr  = fa;
    l_req   = lr;
    l_we    = lw;
    l_lock  = lk;
    l_addr  = la;
    l_wdata = ld;
  endtask

  task automatic check_resp();
    check_eq("rvalid_excl", 32'(f_rvalid & l_rvalid), 32'd0);
    if (exp_f_q.size() > 0) begin
      check_eq("f_rvalid", 32'(f_rvalid), 32'd1);
      check_eq("f_rdata", f_rdata, exp_f_q.pop_front());
    end else begin
      check_eq("f_rvalid_idle", 32'(f_rvalid), 32'd0);
      check_eq("f_rdata_idle", f_rdata, 32'd0);
    end
    if (exp_l_q.size() > 0) begin
      check_eq("l_rvalid", 32'(l_rvalid), 32'd1);
      check_eq("l_rdata", l_rdata, exp_l_q.pop_front());
    end else begin
      check_eq("l_rvalid_idle", 32'(l_rvalid), 32'd0);
      check_eq("l_rdata_idle", l_rdata, 32'd0);
    end
  endtask

  // One clock cycle with the currently driven inputs; ef/el are the grants
  // the bench expects for this cycle.
  task automatic cycle(input logic ef, input logic el);
    logic l_in;
    logic [AW-1:0] exp_addr;
    @(negedge clk);
    check_resp();
    l_in = (l_addr < AW'(DEPTH));
    check_eq("f_ready", 32'(f_ready), 32'(ef));
    check_eq("l_ready", 32'(l_ready), 32'(el));
    check_eq("l_err", 32'(l_err), 32'(el && !l_in));
    check_eq("mem_rw", 32'(mem_rw), 32'(!(el && l_we && l_in)));
    exp_addr = el ? l_addr : (ef ? f_addr : '0);
    check_eq("mem_addr", 32'(mem_addr), 32'(exp_addr));
    if (el && l_we) check_eq("mem_wdata", mem_wdata, l_wdata);
    if (!el && !ef) check_eq("mem_wdata_idle", mem_wdata, 32'd0);
    if (ef) exp_f_q.push_back((f_addr < AW'(DEPTH)) ? model_mem[f_addr[3:0]] : 32'd0);
    if (el && !l_we) exp_l_q.push_back(l_in ? model_mem[l_addr[3:0]] : 32'd0);
    if (el && l_we && l_in) model_mem[l_addr[3:0]] = l_wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [AW-1:0] fa;
    logic          lw_cur;
    logic [DW-1:0] ld_cur;
    logic          lr;
    logic          ef;
    int            k;

    for (int i = 0; i < DEPTH; i++) model_mem[i] = boot_word(i);

    // Reset values, with a fetch already requesting.
    rst = 1'b1;
    drive(1'b1, 5'd3, 1'b0, 1'b0, 1'b0, '0, '0);
    #3;
    check_eq("rst_f_ready", 32'(f_ready), 32'd0);
    check_eq("rst_l_ready", 32'(l_ready), 32'd0);
    check_eq("rst_f_rvalid", 32'(f_rvalid), 32'd0);
    check_eq("rst_l_rvalid", 32'(l_rvalid), 32'd0);
    check_eq("rst_l_err", 32'(l_err), 32'd0);
    check_eq("rst_mem_rw", 32'(mem_rw), 32'd1);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_resp_sel", 32'(dbg_resp_sel), 32'(RESP_NONE));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset mid-read: fetch addr 3 granted, then rst before its response.
    cycle(1'b1, 1'b0);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_f_rvalid", 32'(f_rvalid), 32'd0);
    check_eq("mid_rst_l_rvalid", 32'(l_rvalid), 32'd0);
    check_eq("mid_rst_f_ready", 32'(f_ready), 32'd0);
    check_eq("mid_rst_mem_rw", 32'(mem_rw), 32'd1);
    check_eq("mid_rst_f_rdata", f_rdata, 32'd0);
    exp_f_q.delete();
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);

    // Fetch only, back-to-back over the boot words.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, AW'(i), 1'b0, 1'b0, 1'b0, '0, '0);
      cycle(1'b1, 1'b0);
    end
    idle();
    cycle(1'b0, 1'b0);

    // Loader write then read-back of the same word.
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0, 5'd5, 32'hDEAD_BEEF);
    cycle(1'b0, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 5'd5, '0);
    cycle(1'b0, 1'b1);
    idle();
    cycle(1'b0, 1'b0);

    // Starvation: both ports busy -> L,L,L,L,F repeating.
    fa     = 5'd8;
    k      = 0;
    lw_cur = 1'($urandom_range(0, 1));
    ld_cur = $urandom;
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, fa, 1'b1, lw_cur, 1'b0, AW'(8 + (k % 8)), ld_cur);
      ef = ((i % 5) == 4);
      cycle(ef, !ef);
      if (ef) begin
        fa = fa + 5'd1;
      end else begin
        k++;
        lw_cur = 1'($urandom_range(0, 1));
        ld_cur = $urandom;
      end
    end
    idle();
    cycle(1'b0, 1'b0);

    // Lock: fetch never granted for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      lr = 1'($urandom_range(0, 1));
      drive(1'b1, 5'd2, lr, 1'b0, 1'b1, AW'($urandom_range(0, 15)), '0);
      cycle(1'b0, lr);
    end
    // Lock released: streak restarts from zero.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'd2, 1'b1, 1'b0, 1'b0, AW'(i), '0);
      cycle(i == 4, i != 4);
    end
    drive(1'b1, 5'd3, 1'b0, 1'b0, 1'b0, '0, '0);
    cycle(1'b1, 1'b0);
    idle();
    cycle(1'b0, 1'b0);

    // Out-of-range accesses.
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0, 5'd20, 32'h1234_5678);
    cycle(1'b0, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 5'd20, '0);
    cycle(1'b0, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 5'd4, '0);
    cycle(1'b0, 1'b1);
    drive(1'b1, 5'd25, 1'b0, 1'b0, 1'b0, '0, '0);
    cycle(1'b1, 1'b0);
    idle();
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);

    check_eq("f_q_drained", 32'(exp_f_q.size()), 32'd0);
    check_eq("l_q_drained", 32'(exp_l_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
